// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the floating-point add/subtract control unit.
package fp_ctrl_pkg;

    localparam int NORM_MAX = 24;
    localparam int COUNT_W  = 5;
    localparam int EXP_MAX  = 254;
    localparam int EXP_MIN  = 1;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/fp_add_control_norm_counter.sv
// Iteration counter bounding the left-shift normalize loop.
module norm_counter #(
    parameter int COUNT_W  = 5,
    parameter int NORM_MAX = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    logic [COUNT_W-1:0] cnt_q, cnt_d;

    assign at_max_o = (cnt_q == COUNT_W'(NORM_MAX));

    // Saturates at NORM_MAX so a stuck-low msb flag cannot wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !at_max_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fp_add_control.sv
// Sequencer for the single-precision add/subtract datapath: compare, align,
// add, normalize loop, round and one optional renormalize pass.
module fp_add_control #(
    parameter int NORM_MAX = fp_ctrl_pkg::NORM_MAX,
    parameter int COUNT_W  = fp_ctrl_pkg::COUNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic sub,
    input  logic exp_a_menor,
    input  logic mant_carry,
    input  logic mant_msb,
    input  logic mant_zero,
    input  logic exp_overflow,
    input  logic exp_underflow,
    input  logic round_carry,
    output logic decisor_mux_expoentes,
    output logic decisor_mux_expoente_escolhido,
    output logic decisor_mux_escolhe_shift_right,
    output logic decisor_mux_entrada_dois_ula,
    output logic decisor_mux_saida_big_ula,
    output logic decisor_shift_right_left,
    output logic subtrador_Somador_subtrador,
    output logic alu_sub,
    output logic exp_en,
    output logic mant_en,
    output logic round_en,
    output logic busy,
    output logic done,
    output logic overflow,
    output logic underflow
);
    import fp_ctrl_pkg::*;

    state_e state_q, state_d;

    logic sub_q, a_small_q, a_small_d, renorm_q;
    logic ovf_q, unf_q;
    logic mux_exp_q, mux_esc_q, mux_shr_q, mux_b_q, mux_out_q;
    logic alu_sub_q, exp_en_q, mant_en_q, round_en_q, busy_q, done_q;
    logic accept, in_norm, shr, shl, renorm_go, at_max;

    assign accept    = (state_q == IDLE) && start;
    assign in_norm   = (state_q == NORM);
    assign shr       = in_norm && !mant_zero && mant_carry;
    assign shl       = in_norm && !mant_zero && !mant_carry && !mant_msb && !at_max;
    assign renorm_go = (state_q == CHECK) && round_carry && !renorm_q;
    assign a_small_d = accept ? exp_a_menor : a_small_q;

    norm_counter #(
        .COUNT_W  (COUNT_W),
        .NORM_MAX (NORM_MAX)
    ) u_norm_counter (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (accept || renorm_go),
        .inc_i    (shl),
        .at_max_o (at_max)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPARE;
            COMPARE: state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM: begin
                if (mant_zero)
                    state_d = DONE;
                else if (mant_carry)
                    state_d = exp_overflow ? DONE : ROUND;
                else if (shl)
                    state_d = exp_underflow ? DONE : NORM;
                else
                    state_d = ROUND;
            end
            ROUND:   state_d = CHECK;
            CHECK:   state_d = renorm_go ? NORM : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sub_q      <= 1'b0;
            a_small_q  <= 1'b0;
            renorm_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            mux_exp_q  <= 1'b0;
            mux_esc_q  <= 1'b0;
            mux_shr_q  <= 1'b0;
            mux_b_q    <= 1'b0;
            mux_out_q  <= 1'b0;
            alu_sub_q  <= 1'b0;
            exp_en_q   <= 1'b0;
            mant_en_q  <= 1'b0;
            round_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_small_q <= a_small_d;
            if (accept) begin
                sub_q    <= sub;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
                renorm_q <= 1'b0;
            end
            if (shr && exp_overflow)
                ovf_q <= 1'b1;
            if (shl && exp_underflow)
                unf_q <= 1'b1;
            if (renorm_go)
                renorm_q <= 1'b1;

            mux_exp_q  <= (state_d == COMPARE) && a_small_d;
            mux_shr_q  <= (state_d == ALIGN) && !a_small_q;
            mux_b_q    <= (state_d == ALIGN) && !a_small_q;
            // The first NORM of an operation consumes the raw big-ULA sum.
            mux_out_q  <= (state_d == NORM) && (state_q != ADD);
            mux_esc_q  <= (state_d == NORM) && (state_q != ADD);
            alu_sub_q  <= (state_d == ADD) && sub_q;
            exp_en_q   <= (state_d == COMPARE);
            mant_en_q  <= (state_d == ADD) || (state_d == ROUND);
            round_en_q <= (state_d == ROUND);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    // Shift strobes follow the flags of the current NORM cycle so a right
    // shift costs no extra cycle; they are gated by the registered state.
    assign decisor_mux_expoentes           = mux_exp_q;
    assign decisor_mux_expoente_escolhido  = mux_esc_q;
    assign decisor_mux_escolhe_shift_right = mux_shr_q;
    assign decisor_mux_entrada_dois_ula    = mux_b_q;
    assign decisor_mux_saida_big_ula       = mux_out_q;
    assign decisor_shift_right_left        = shr;
    assign subtrador_Somador_subtrador     = shl;
    assign alu_sub                         = alu_sub_q;
    assign exp_en                          = exp_en_q | shr | shl;
    assign mant_en                         = mant_en_q | shr | shl;
    assign round_en                        = round_en_q;
    assign busy                            = busy_q;
    assign done                            = done_q;
    assign overflow                        = ovf_q;
    assign underflow                       = unf_q;

endmodule

// File: tb/tb_fp_add_control.sv
// Directed bench for fp_add_control: per-cycle flag masks drive each operation.
module tb_fp_add_control;

    logic clk = 1'b0;
    logic reset, start, sub, exp_a_menor;
    logic mant_carry, mant_msb, mant_zero, exp_overflow, exp_underflow, round_carry;
    logic decisor_mux_expoentes, decisor_mux_expoente_escolhido;
    logic decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula;
    logic decisor_mux_saida_big_ula, decisor_shift_right_left;
    logic subtrador_Somador_subtrador, alu_sub, exp_en, mant_en, round_en;
    logic busy, done, overflow, underflow;

    int checks = 0;
    int errors = 0;

    int   r_done, r_shr, r_shl, r_exp, r_fb, r_rnd, r_blow;
    logic r_ovf, r_unf;

    always #5 clk = ~clk;

    fp_add_control dut (
        .clk                             (clk),
        .reset                           (reset),
        .start                           (start),
        .sub                             (sub),
        .exp_a_menor                     (exp_a_menor),
        .mant_carry                      (mant_carry),
        .mant_msb                        (mant_msb),
        .mant_zero                       (mant_zero),
        .exp_overflow                    (exp_overflow),
        .exp_underflow                   (exp_underflow),
        .round_carry                     (round_carry),
        .decisor_mux_expoentes           (decisor_mux_expoentes),
        .decisor_mux_expoente_escolhido  (decisor_mux_expoente_escolhido),
        .decisor_mux_escolhe_shift_right (decisor_mux_escolhe_shift_right),
        .decisor_mux_entrada_dois_ula    (decisor_mux_entrada_dois_ula),
        .decisor_mux_saida_big_ula       (decisor_mux_saida_big_ula),
        .decisor_shift_right_left        (decisor_shift_right_left),
        .subtrador_Somador_subtrador     (subtrador_Somador_subtrador),
        .alu_sub                         (alu_sub),
        .exp_en                          (exp_en),
        .mant_en                         (mant_en),
        .round_en                        (round_en),
        .busy                            (busy),
        .done                            (done),
        .overflow                        (overflow),
        .underflow                       (underflow)
    );

    function automatic logic [14:0] all_outs();
        return {decisor_mux_expoentes, decisor_mux_expoente_escolhido,
                decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula,
                decisor_mux_saida_big_ula, decisor_shift_right_left,
                subtrador_Somador_subtrador, alu_sub, exp_en, mant_en, round_en,
                busy, done, overflow, underflow};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_flags();
        mant_carry = 0; mant_msb = 1; mant_zero = 0;
        exp_overflow = 0; exp_underflow = 0; round_carry = 0;
    endtask

    // Cycle 1 is the cycle right after the start-accepting edge.
    task automatic run_op(input string t, input logic s, input logic am,
                          input logic [63:0] carry_m, input logic [63:0] msb0_m,
                          input logic [63:0] zero_m, input logic [63:0] ovf_m,
                          input logic [63:0] unf_m, input logic [63:0] rc_m);
        r_done = 0; r_shr = 0; r_shl = 0; r_exp = 0; r_fb = 0; r_rnd = 0; r_blow = 0;
        r_ovf = 0; r_unf = 0;
        start = 1; sub = s; exp_a_menor = am;
        tick();
        start = 0;
        for (int c = 1; c <= 60 && r_done == 0; c++) begin
            mant_carry    = carry_m[c];
            mant_msb      = !msb0_m[c];
            mant_zero     = zero_m[c];
            exp_overflow  = ovf_m[c];
            exp_underflow = unf_m[c];
            round_carry   = rc_m[c];
            #1;
            if (c == 1) begin
                chk({t, "_c1_muxexp"}, decisor_mux_expoentes, am);
                chk({t, "_c1_flags"}, {overflow, underflow}, 0);
            end
            if (c == 2) chk({t, "_c2_align"}, {decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula}, {!am, !am});
            if (c == 3) chk({t, "_c3_add"}, {alu_sub, mant_en, decisor_mux_saida_big_ula}, {s, 1'b1, 1'b0});
            if (decisor_shift_right_left) r_shr++;
            if (subtrador_Somador_subtrador) r_shl++;
            if (exp_en) r_exp++;
            if (decisor_mux_saida_big_ula) r_fb++;
            if (round_en) r_rnd++;
            if (!busy) r_blow++;
            if (done) begin
                r_done = c; r_ovf = overflow; r_unf = underflow;
            end
            tick();
        end
        idle_flags();
        chk({t, "_idle_after"}, {busy, done}, 0);
    endtask

    task automatic expect_op(input string t, input int d, input int shr, input int shl,
                             input int ex, input int fb, input int rnd,
                             input logic ovf, input logic unf);
        chk({t, "_done_cycle"}, r_done, d);
        chk({t, "_right_shifts"}, r_shr, shr);
        chk({t, "_left_shifts"}, r_shl, shl);
        chk({t, "_exp_en_cycles"}, r_exp, ex);
        chk({t, "_feedback_cycles"}, r_fb, fb);
        chk({t, "_round_cycles"}, r_rnd, rnd);
        chk({t, "_busy_low"}, r_blow, 0);
        chk({t, "_flags"}, {r_ovf, r_unf}, {ovf, unf});
    endtask

    initial begin
        int nd;
        reset = 1; start = 0; sub = 0; exp_a_menor = 0;
        idle_flags();
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 0);
        reset = 0;
        tick();

        // 1.0 + 1.0: carry on first NORM
        run_op("add11", 0, 0, 64'h10, 0, 0, 0, 0, 0);
        expect_op("add11", 7, 1, 0, 2, 0, 1, 0, 0);

        // 1.0 - 0.75: two left shifts
        run_op("sub075", 1, 0, 0, 64'h30, 0, 0, 0, 0);
        expect_op("sub075", 9, 0, 2, 3, 2, 1, 0, 0);

        // 1.0 - 1.0: zero result, and zero wins over a simultaneous carry
        run_op("sub11", 1, 0, 0, 0, 64'h10, 0, 0, 0);
        expect_op("sub11", 5, 0, 0, 1, 0, 0, 0, 0);
        run_op("zero_prio", 1, 1, 64'h10, 0, 64'h10, 0, 0, 0);
        expect_op("zero_prio", 5, 0, 0, 1, 0, 0, 0, 0);

        // exponent overflow on right shift, flag held in IDLE
        run_op("ovf", 0, 0, 64'h10, 0, 0, 64'h10, 0, 0);
        expect_op("ovf", 5, 1, 0, 2, 0, 0, 1, 0);
        chk("ovf_held0", overflow, 1);
        repeat (3) tick();
        chk("ovf_held3", overflow, 1);

        // round carry: one renormalize pass, second carry ignored
        run_op("renorm", 0, 1, 0, 0, 0, 0, 0, 64'h240);
        expect_op("renorm", 10, 0, 0, 1, 1, 2, 0, 0);

        // exponent underflow on left shift
        run_op("unf", 1, 0, 0, 64'h10, 0, 0, 64'h10, 0);
        expect_op("unf", 5, 0, 1, 2, 0, 0, 0, 1);

        // msb never rises: loop capped at 24 left shifts
        run_op("cap", 1, 0, 0, ~64'hF, 0, 0, 0, 0);
        expect_op("cap", 31, 0, 24, 25, 24, 1, 0, 0);

        // start held high: ignored while busy, back-to-back accept after DONE
        start = 1; sub = 0; exp_a_menor = 0;
        tick();
        nd = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) mant_carry = 1; else mant_carry = 0;
            #1;
            if (done) nd++;
            tick();
        end
        mant_carry = 0;
        chk("hold_done_c7", done, 1);
        chk("hold_early_done", nd, 0);
        tick();
        chk("b2b_idle", {busy, done}, 0);
        tick();
        chk("b2b_accept", busy, 1);
        start = 0;
        tick(); tick(); tick();
        mant_msb = 0;
        #1;
        chk("pre_reset_shl", subtrador_Somador_subtrador, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("reset_mid_outputs", all_outs(), 0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("reset_no_done", nd, 0);
        idle_flags();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fp_add_control.md
Name: fp_add_control

Overview:
- FSM control unit that sequences the single-precision floating-point add/subtract datapath.
- Steps per operation: exponent compare, significand alignment, big-ULA add, normalize loop (shift left/right with exponent inc/dec), round, renormalize check.
- Drives every mux decisor and register enable of the datapath and consumes its status flags.
- Talks to the outside through a start/done handshake.

Parameters:
- NORM_MAX, 24, maximum left-shift iterations in one normalize pass before forcing ROUND.
- COUNT_W, 5, width of the normalize iteration counter; must hold NORM_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; returns the FSM to IDLE.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  1 = subtract, 0 = add; latched on accepted start.
- exp_a_menor  input  1  from small ULA: exponent of input_1 < exponent of input_2.
- mant_carry  input  1  big-ULA/normalizer result overflowed past the hidden bit.
- mant_msb  input  1  hidden-bit position of the current significand is 1.
- mant_zero  input  1  current significand is all zero.
- exp_overflow  input  1  exponent incrementer would exceed 254.
- exp_underflow  input  1  exponent decrementer would go below 1.
- round_carry  input  1  rounding produced a carry out of the significand.
- decisor_mux_expoentes  output  1  1 = take input_2 exponent (the larger).
- decisor_mux_expoente_escolhido  output  1  0 = exponent mux, 1 = fed-back exponent.
- decisor_mux_escolhe_shift_right  output  1  1 = shift input_2 significand.
- decisor_mux_entrada_dois_ula  output  1  1 = input_1 significand to big-ULA port B.
- decisor_mux_saida_big_ula  output  1  0 = big-ULA result, 1 = fed-back normalized significand.
- decisor_shift_right_left  output  1  1 = right shift, 0 = left shift.
- subtrador_Somador_subtrador  output  1  1 = decrement exponent, 0 = increment.
- alu_sub  output  1  big-ULA operation (latched sub).
- exp_en  output  1  load exponent register.
- mant_en  output  1  load significand register.
- round_en  output  1  apply rounding.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at completion.
- overflow  output  1  result overflowed; held until next accepted start.
- underflow  output  1  result underflowed; held until next accepted start.

Behaviour:
- Reset: state=IDLE, counter=0, all outputs 0.
  - Reset mid-operation aborts the operation with no done pulse.
  - Reset has priority over every other event.
- Control outputs are a registered state decode. Decisor values not listed for a state are 0.
- IDLE:
  - start=1 latches sub, latches a_small=exp_a_menor, clears overflow/underflow, clears counter, goes to COMPARE.
  - start outside IDLE is ignored.
- COMPARE:
  - decisor_mux_expoentes=a_small; exp_en=1 (larger exponent captured).
  - Next state: ALIGN.
- ALIGN:
  - decisor_mux_escolhe_shift_right=!a_small; decisor_mux_entrada_dois_ula=!a_small.
  - Shift amount comes from the small-ULA register.
  - Next state: ADD.
- ADD:
  - alu_sub=sub; mant_en=1; decisor_mux_saida_big_ula=0.
  - Next state: NORM.
- NORM (decisor_mux_saida_big_ula=1 and decisor_mux_expoente_escolhido=1 on every NORM cycle after the first of the operation), evaluated in priority order:
  1. mant_zero: go to DONE (zero result, no flags).
  2. mant_carry:
     - Drive right shift 1 (decisor_shift_right_left=1), increment exponent (subtrador=0), exp_en=mant_en=1.
     - If exp_overflow: set overflow and go to DONE; else go to ROUND.
  3. !mant_msb and counter<NORM_MAX:
     - Drive left shift 1, decrement exponent (subtrador=1), exp_en=mant_en=1, counter+1, stay in NORM.
     - If exp_underflow: set underflow and go to DONE instead.
  4. Otherwise (normalized, or counter==NORM_MAX): go to ROUND.
- ROUND:
  - round_en=1; mant_en=1.
  - Next state: CHECK.
- CHECK:
  - round_carry=1 and no renormalize yet this operation: clear counter, go to NORM.
  - Otherwise: go to DONE.
  - Renormalize happens at most once per operation.
- DONE:
  - done=1 for exactly one cycle; flags are valid.
  - Next state: IDLE.
- Latency: measured from the start-accepting edge to the done pulse.
  - No normalization shifts: done during the 7th cycle.
  - Each left shift adds 1 cycle.
  - A right shift adds 0 cycles.
  - A round renormalize adds 3 cycles.
- A back-to-back start may be accepted in the cycle after DONE.

Decomposition:
- Shared package fp_ctrl_pkg holds:
  - state enum (IDLE, COMPARE, ALIGN, ADD, NORM, ROUND, CHECK, DONE);
  - constants NORM_MAX, EXP_MAX=254, EXP_MIN=1.
- One sub-module is natural: norm_counter (COUNT_W-bit counter with clear, enable and at_max output).

Test Plan:
- 1.0+1.0 (mant_carry=1 in first NORM, round_carry=0) -> done in 7th cycle after start; exactly one right shift with increment; no flags.
- 1.0-0.75 (mant_msb=0 for 2 NORM cycles) -> 2 left-shift/decrement cycles, done in 9th cycle, busy high throughout.
- 1.0-1.0 (mant_zero=1 in NORM) -> no exp_en in NORM, done in 5th cycle, no flags.
- exp_overflow=1 with mant_carry=1 -> overflow=1 at done, held through IDLE until next start clears it.
- round_carry=1 in CHECK -> one extra NORM/ROUND/CHECK pass; second round_carry ignored; done in 10th cycle.
- reset asserted in NORM, and start pulsed while busy -> no done pulse, all outputs 0 the next cycle; start ignored while busy.
